ccr_ctrl: RTL and testbench
===========================

# ccr_ctrl

Flag-update sequencer sitting between the execute stage and the condition-code register. Each cycle it arbitrates between interrupt-return restore, explicit carry set/clear, and masked ALU flag updates. It issues at most one registered write command (flags, mask, enable) to the flag register. It also keeps a LIFO shadow stack of flag snapshots for interrupt entry (save) and return (restore).

## Interface
- DEPTH, 4, shadow-stack entries; power of two, 2..16
- clk  in  1  rising-edge clock
- rst  in  1  synchronous, active-high reset
- alu_valid  in  1  ALU flag update request this cycle
- alu_flags  in  4  {V,C,N,Z} from ALU, bit 0 = Z, 1 = N, 2 = C, 3 = V
- alu_mask  in  4  per-flag update mask, same bit order
- setc  in  1  set carry (bit 2) to 1
- clrc  in  1  clear carry (bit 2) to 0
- int_save  in  1  push effective flags onto shadow stack
- rti_restore  in  1  pop top of stack into flag register
- err_clr  in  1  clear stk_err
- ccr_q  in  4  current flag register contents
- ccr_flags  out  4  flag values to flag register (Z,N,C,V order as above)
- ccr_mask  out  4  write mask to flag register
- ccr_en  out  1  write enable to flag register, one-cycle pulse
- stk_cnt  out  $clog2(DEPTH)+1  entries in use
- stk_full  out  1  stk_cnt == DEPTH
- stk_empty  out  1  stk_cnt == 0
- stk_err  out  1  sticky overflow/underflow/conflict indicator

## Operation
- Write-source priority, one winner per cycle: rti_restore > (setc|clrc) > alu_valid.
- rti_restore, stack non-empty: pop top entry, write it with mask 4'b1111.
- setc/clrc: write with mask 4'b0100, C = 1 for setc, C = 0 for clrc. If both are asserted, clrc wins.
- alu_valid: write alu_flags with alu_mask. If alu_mask == 0, no write and ccr_en stays low.
- Losing requests in a cycle are dropped, not queued.
- Effective flags E at cycle t:
  - if ccr_en is high at t: (ccr_flags & ccr_mask) | (ccr_q & ~ccr_mask)
  - otherwise: ccr_q
- int_save pushes E. It captures the state before any write requested in the same cycle, so a save and an ALU update in one cycle save the pre-update flags.
- Stack pointer update:
  - int_save alone, not full: cnt+1
  - int_save when full: drop the push, set stk_err, cnt unchanged
  - rti_restore when empty: no write, set stk_err, and lower-priority requests that cycle still arbitrate normally
  - int_save with rti_restore in the same cycle: the restore executes, the save is dropped, stk_err is set
- stk_err stays set until err_clr. If err_clr and a new error coincide, the error wins (stk_err = 1).
- Stack storage is not cleared on reset; only the pointer resets. Entries above stk_cnt are don't-care.

## Timing
- Requests are sampled at edge t. ccr_en/ccr_flags/ccr_mask are registered and valid during cycle t+1 for exactly one cycle. The flag register captures at the end of t+1, and ccr_q reflects the write in t+2.
- Back-to-back requests produce back-to-back ccr_en pulses; there is no throughput limit.
- stk_cnt/stk_full/stk_empty are registered and update one cycle after the push/pop request. The pop data is read from entry cnt-1 in the request cycle.
- Reset values: ccr_en = 0, ccr_mask = 0, ccr_flags = 0, stk_cnt = 0, stk_empty = 1, stk_full = 0, stk_err = 0.
- rst asserted mid-operation: any pending write command is cancelled (ccr_en = 0 next cycle) and the stack is emptied. Requests in the reset cycle are ignored.

## Test plan
- ALU update: ccr_q = 0, alu_valid with flags 4'b1111 and mask 4'b0101 -> next cycle ccr_en = 1, mask 0101, flags 1111; ccr_en low the cycle after.
- Priority: rti_restore (top = 4'b1010), setc and alu_valid in one cycle -> single write of 1010 with mask 1111; setc and ALU are dropped.
- Save hazard: cycle t alu_valid with flags 0001 and mask 0001 (ccr_q = 0110); cycle t+1 int_save -> pushed entry = 0111; later restore writes 0111.
- Stack bounds (DEPTH = 4): 5 saves -> stk_cnt = 4, stk_full = 1, stk_err = 1. Then 4 restores write entries in LIFO order. A 5th restore gives no ccr_en, stk_err stays 1, err_clr drops it to 0.
- Conflicts: setc and clrc together -> mask 0100 with C = 0. int_save and rti_restore together -> cnt decrements by 1 and stk_err = 1.
- Reset mid-operation: with 2 entries and a pending ccr_en, assert rst for one cycle -> ccr_en = 0, stk_cnt = 0, stk_empty = 1, stk_err = 0.

Source files
------------

// File: rtl/ccr_ctrl.sv
// Condition-code write sequencer: arbitrates restore / carry / ALU flag writes into one
// registered write command and keeps a LIFO shadow stack of flag snapshots.
module ccr_ctrl #(
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     alu_valid,
    input  logic [3:0]               alu_flags,
    input  logic [3:0]               alu_mask,
    input  logic                     setc,
    input  logic                     clrc,
    input  logic                     int_save,
    input  logic                     rti_restore,
    input  logic                     err_clr,
    input  logic [3:0]               ccr_q,
    output logic [3:0]               ccr_flags,
    output logic [3:0]               ccr_mask,
    output logic                     ccr_en,
    output logic [$clog2(DEPTH):0]   stk_cnt,
    output logic                     stk_full,
    output logic                     stk_empty,
    output logic                     stk_err
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [3:0]    stack [DEPTH];
    logic [CW-1:0] cnt;
    logic [AW-1:0] top_idx;
    logic [AW-1:0] push_idx;
    logic [3:0]    eff;
    logic          empty;
    logic          full;
    logic          pop_ok;
    logic          push_ok;
    logic          err_set;
    logic          wr_en_p0;
    logic [3:0]    wr_flags_p0;
    logic [3:0]    wr_mask_p0;

    assign empty    = (cnt == '0);
    assign full     = (cnt == CW'(DEPTH));
    assign top_idx  = AW'(cnt - CW'(1));
    assign push_idx = AW'(cnt);

    // Flags as the register will hold them once the in-flight write lands; a save
    // must see this, not the stale ccr_q.
    assign eff = ccr_en ? ((ccr_flags & ccr_mask) | (ccr_q & ~ccr_mask)) : ccr_q;

    assign pop_ok  = rti_restore & ~empty;
    assign push_ok = int_save & ~rti_restore & ~full;
    assign err_set = (rti_restore & empty) | (int_save & rti_restore) | (int_save & full);

    always_comb begin
        wr_en_p0    = 1'b0;
        wr_flags_p0 = ccr_flags;
        wr_mask_p0  = ccr_mask;
        if (pop_ok) begin
            wr_en_p0    = 1'b1;
            wr_flags_p0 = stack[top_idx];
            wr_mask_p0  = 4'b1111;
        end else if (setc | clrc) begin
            wr_en_p0    = 1'b1;
            wr_flags_p0 = clrc ? 4'b0000 : 4'b0100;
            wr_mask_p0  = 4'b0100;
        end else if (alu_valid && (alu_mask != 4'b0000)) begin
            wr_en_p0    = 1'b1;
            wr_flags_p0 = alu_flags;
            wr_mask_p0  = alu_mask;
        end
    end

    // p0 -> p1: registered write command to the flag register
    always_ff @(posedge clk) begin
        if (rst) begin
            ccr_en    <= 1'b0;
            ccr_flags <= 4'b0000;
            ccr_mask  <= 4'b0000;
        end else begin
            ccr_en    <= wr_en_p0;
            ccr_flags <= wr_flags_p0;
            ccr_mask  <= wr_mask_p0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt     <= '0;
            stk_err <= 1'b0;
        end else begin
            if (push_ok) begin
                cnt <= cnt + CW'(1);
            end else if (pop_ok) begin
                cnt <= cnt - CW'(1);
            end
            if (err_set) begin
                stk_err <= 1'b1;
            end else if (err_clr) begin
                stk_err <= 1'b0;
            end
        end
    end

    // Storage is deliberately left out of reset; only the pointer defines validity.
    always_ff @(posedge clk) begin
        if (!rst && push_ok) begin
            stack[push_idx] <= eff;
        end
    end

    assign stk_cnt   = cnt;
    assign stk_full  = full;
    assign stk_empty = empty;

endmodule

// File: tb/tb_ccr_ctrl.sv
// Scoreboard bench for ccr_ctrl: a queue-based reference model predicts write commands
// and stack state; a negedge monitor consumes predicted writes as ccr_en pulses appear.
module tb_ccr_ctrl;

    localparam int DEPTH = 4;
    localparam int CW = $clog2(DEPTH) + 1;

    logic          clk;
    logic          rst;
    logic          alu_valid;
    logic [3:0]    alu_flags;
    logic [3:0]    alu_mask;
    logic          setc;
    logic          clrc;
    logic          int_save;
    logic          rti_restore;
    logic          err_clr;
    logic [3:0]    ccr_q;
    logic [3:0]    ccr_flags;
    logic [3:0]    ccr_mask;
    logic          ccr_en;
    logic [CW-1:0] stk_cnt;
    logic          stk_full;
    logic          stk_empty;
    logic          stk_err;

    ccr_ctrl #(.DEPTH(DEPTH)) dut (
        .clk(clk), .rst(rst), .alu_valid(alu_valid), .alu_flags(alu_flags),
        .alu_mask(alu_mask), .setc(setc), .clrc(clrc), .int_save(int_save),
        .rti_restore(rti_restore), .err_clr(err_clr), .ccr_q(ccr_q),
        .ccr_flags(ccr_flags), .ccr_mask(ccr_mask), .ccr_en(ccr_en),
        .stk_cnt(stk_cnt), .stk_full(stk_full), .stk_empty(stk_empty), .stk_err(stk_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [3:0] flags;
        logic [3:0] mask;
        logic [3:0] care;
    } wr_t;

    wr_t        exp_q [$];
    wr_t        mon_e;
    logic [3:0] mstk [$];
    logic       m_en;
    logic [3:0] m_flags;
    logic [3:0] m_mask;
    logic       m_err;
    int         checks = 0;
    int         errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (ccr_en === 1'b1) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_write: got flags %0h mask %0h, expected no write at %0t",
                         ccr_flags, ccr_mask, $time);
            end else begin
                mon_e = exp_q.pop_front();
                chk("wr_flags", ccr_flags & mon_e.care, mon_e.flags & mon_e.care);
                chk("wr_mask", ccr_mask, mon_e.mask);
            end
        end
    end

    task automatic clr_in();
        rst = 0; alu_valid = 0; alu_flags = 0; alu_mask = 0; setc = 0; clrc = 0;
        int_save = 0; rti_restore = 0; err_clr = 0;
    endtask

    // One clock of model + DUT; inputs must be set before calling.
    task automatic step();
        logic [3:0] e;
        logic       n_en;
        logic [3:0] n_f;
        logic [3:0] n_m;
        logic       n_err;
        logic       was_empty;
        logic       err_set;
        logic [3:0] top;
        wr_t        w;
        e = m_en ? ((m_flags & m_mask) | (ccr_q & ~m_mask)) : ccr_q;
        n_en = 0; n_f = m_flags; n_m = m_mask; n_err = m_err; err_set = 0;
        w = '{flags: 4'h0, mask: 4'h0, care: 4'h0};
        if (rst) begin
            mstk.delete();
            n_f = 0; n_m = 0; n_err = 0;
        end else begin
            was_empty = (mstk.size() == 0);
            if (rti_restore && !was_empty) begin
                top = mstk.pop_back();
                n_en = 1; n_f = top; n_m = 4'hF;
                w = '{flags: top, mask: 4'hF, care: 4'hF};
            end else if (setc || clrc) begin
                n_en = 1; n_f = clrc ? 4'h0 : 4'h4; n_m = 4'h4;
                w = '{flags: n_f, mask: 4'h4, care: 4'h4};
            end else if (alu_valid && alu_mask != 0) begin
                n_en = 1; n_f = alu_flags; n_m = alu_mask;
                w = '{flags: alu_flags, mask: alu_mask, care: 4'hF};
            end
            if (n_en) exp_q.push_back(w);
            if (rti_restore) begin
                err_set = was_empty || int_save;
            end else if (int_save) begin
                if (mstk.size() == DEPTH) err_set = 1;
                else mstk.push_back(e);
            end
            n_err = err_set ? 1'b1 : (err_clr ? 1'b0 : m_err);
        end
        @(posedge clk);
        #1;
        if (m_en) ccr_q = (m_flags & m_mask) | (ccr_q & ~m_mask);
        m_en = n_en; m_flags = n_f; m_mask = n_m; m_err = n_err;
        chk("ccr_en", ccr_en, m_en);
        chk("stk_cnt", stk_cnt, mstk.size());
        chk("stk_full", stk_full, mstk.size() == DEPTH);
        chk("stk_empty", stk_empty, mstk.size() == 0);
        chk("stk_err", stk_err, m_err);
    endtask

    initial begin
        m_en = 0; m_flags = 0; m_mask = 0; m_err = 0;
        clr_in();
        ccr_q = 4'h0;
        rst = 1;
        step();
        step();
        chk("rst_flags", ccr_flags, 4'h0);
        chk("rst_mask", ccr_mask, 4'h0);
        rst = 0;
        step();

        // ALU masked update
        alu_valid = 1; alu_flags = 4'hF; alu_mask = 4'h5;
        step();
        chk("alu_flags_full", ccr_flags, 4'hF);
        clr_in(); step(); step();

        // Priority: restore beats carry and ALU
        ccr_q = 4'hA; int_save = 1; step();
        clr_in(); rti_restore = 1; setc = 1; alu_valid = 1; alu_flags = 4'h3; alu_mask = 4'hF;
        step();
        clr_in(); step(); step();

        // Save sees pending ALU write
        ccr_q = 4'h6; alu_valid = 1; alu_flags = 4'h1; alu_mask = 4'h1; step();
        clr_in(); int_save = 1; step();
        clr_in(); step();
        rti_restore = 1; step();
        chk("hazard_restore", ccr_flags, 4'h7);
        clr_in(); step(); step();

        // Stack bounds
        for (int i = 0; i < 5; i++) begin
            clr_in(); ccr_q = 4'(i + 3); int_save = 1; step();
        end
        for (int i = 0; i < 5; i++) begin
            clr_in(); rti_restore = 1; step();
        end
        clr_in(); err_clr = 1; step();
        clr_in(); step(); step();

        // Conflicts
        setc = 1; clrc = 1; step();
        clr_in(); int_save = 1; step();
        int_save = 1; rti_restore = 1; step();
        clr_in(); err_clr = 1; step();
        clr_in(); step();

        // Reset mid-operation
        for (int i = 0; i < 3; i++) begin
            clr_in(); ccr_q = 4'(9 + i); int_save = 1; step();
        end
        int_save = 1; rti_restore = 1; step();
        clr_in(); alu_valid = 1; alu_flags = 4'hC; alu_mask = 4'hF; step();
        rst = 1; step();
        clr_in(); step(); step();

        // Randomized traffic
        for (int i = 0; i < 3000; i++) begin
            clr_in();
            rst         = ($urandom_range(0, 199) == 0);
            alu_valid   = ($urandom_range(0, 1) == 0);
            alu_flags   = 4'($urandom());
            alu_mask    = 4'($urandom());
            setc        = ($urandom_range(0, 9) == 0);
            clrc        = ($urandom_range(0, 9) == 0);
            int_save    = ($urandom_range(0, 3) == 0);
            rti_restore = ($urandom_range(0, 4) == 0);
            err_clr     = ($urandom_range(0, 9) == 0);
            if ($urandom_range(0, 9) == 0) ccr_q = 4'($urandom());
            step();
        end
        clr_in(); step(); step();
        chk("pending_writes", exp_q.size(), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
